// File: rtl/sample_voice_addr_gen_pkg.sv
// Shared types for the sampler voice address path.
// Build option: SAMPLER_PINGPONG_EN selects whether mode 2 decodes to
// ping-pong or folds onto loop.
package sampler_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_LOOP     = 2'd1,
    MODE_PINGPONG = 2'd2
  } voice_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    HOLD = 2'd3
  } voice_state_t;

  // Raw mode 3 is treated as one-shot. Without ping-pong support, mode 2 plays as a loop.
  function automatic voice_mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_LOOP;
`ifdef SAMPLER_PINGPONG_EN
      2'd2:    return MODE_PINGPONG;
`else
      2'd2:    return MODE_LOOP;
`endif
      default: return MODE_ONESHOT;
    endcase
  endfunction

endpackage

// File: rtl/sample_voice_addr_gen_if.sv
// Voice-control and BRAM-address bundle between the voice allocator (master)
// and the address generator (slave). Per-voice fields are packed with voice 0
// in the least-significant slice.
interface sample_voice_addr_gen_if #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_WIDTH = 13
);

  logic                             sample_tick;
  logic [NUM_VOICES-1:0]            gate_in;
  logic [2*NUM_VOICES-1:0]          mode_in;
  logic [ADDR_WIDTH*NUM_VOICES-1:0] start_addr_in;
  logic [ADDR_WIDTH*NUM_VOICES-1:0] end_addr_in;
  logic [ADDR_WIDTH*NUM_VOICES-1:0] sample_addr;
  logic [NUM_VOICES-1:0]            voice_active;
  logic [NUM_VOICES-1:0]            loop_pulse;

  modport master (
    output sample_tick, gate_in, mode_in, start_addr_in, end_addr_in,
    input  sample_addr, voice_active, loop_pulse
  );

  modport slave (
    input  sample_tick, gate_in, mode_in, start_addr_in, end_addr_in,
    output sample_addr, voice_active, loop_pulse
  );

endinterface

// File: rtl/sample_voice_addr_gen_channel.sv
// One sampler voice: gate edge detect, region latch, play FSM and address counter.
// Build option: SAMPLER_PINGPONG_EN adds the REV state for ping-pong playback.
//
// state | meaning
// IDLE  | gate low, address parked at 0
// FWD   | playing upward toward the latched end
// REV   | playing downward toward the latched start (ping-pong only)
// HOLD  | one-shot finished, address parked at end until gate falls
module voice_addr_channel
  import sampler_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  gate,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  active,
  output logic                  loop_pulse
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_FWD  = FWD;
  localparam logic [1:0] S_HOLD = HOLD;
`ifdef SAMPLER_PINGPONG_EN
  localparam logic [1:0] S_REV  = REV;
`endif

  logic [1:0]            state, nxt_state;
  logic                  gate_prev;
  logic                  rise;
  voice_mode_t           mode_l, nxt_mode;
  logic [ADDR_WIDTH-1:0] start_l, nxt_start;
  logic [ADDR_WIDTH-1:0] end_l, nxt_end;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic                  nxt_pulse;
  logic                  nxt_active;

  assign rise = gate & ~gate_prev;

  // Next-state: gate low dominates, then a trigger, then tick-driven stepping.
  always_comb begin
    nxt_state = state;
    nxt_addr  = addr;
    nxt_pulse = 1'b0;
    nxt_mode  = mode_l;
    nxt_start = start_l;
    nxt_end   = end_l;

    if (!gate) begin
      nxt_state = S_IDLE;
      nxt_addr  = '0;
    end else if (rise) begin
      // A trigger on a tick cycle loads start and does not advance.
      nxt_mode  = decode_mode(mode);
      nxt_start = start_addr;
      nxt_end   = (end_addr < start_addr) ? start_addr : end_addr;
      nxt_addr  = start_addr;
      nxt_state = S_FWD;
    end else if (sample_tick) begin
      case (state)
        S_FWD: begin
          if (addr < end_l) begin
            nxt_addr = addr + 1'b1;
          end else begin
            case (mode_l)
              MODE_LOOP: begin
                nxt_addr  = start_l;
                nxt_pulse = 1'b1;
              end
`ifdef SAMPLER_PINGPONG_EN
              MODE_PINGPONG: begin
                nxt_state = S_REV;
                nxt_addr  = (end_l == start_l) ? start_l : end_l - 1'b1;
                nxt_pulse = 1'b1;
              end
`endif
              default: nxt_state = S_HOLD;
            endcase
          end
        end
`ifdef SAMPLER_PINGPONG_EN
        S_REV: begin
          if (addr > start_l) begin
            nxt_addr = addr - 1'b1;
          end else begin
            nxt_state = S_FWD;
            nxt_addr  = (end_l == start_l) ? start_l : start_l + 1'b1;
            nxt_pulse = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef SAMPLER_PINGPONG_EN
  assign nxt_active = (nxt_state == S_FWD) || (nxt_state == S_REV);
`else
  assign nxt_active = (nxt_state == S_FWD);
`endif

  // State, latched region and registered outputs; reset discards the region.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      gate_prev  <= 1'b0;
      mode_l     <= MODE_ONESHOT;
      start_l    <= '0;
      end_l      <= '0;
      addr       <= '0;
      active     <= 1'b0;
      loop_pulse <= 1'b0;
    end else begin
      state      <= nxt_state;
      gate_prev  <= gate;
      mode_l     <= nxt_mode;
      start_l    <= nxt_start;
      end_l      <= nxt_end;
      addr       <= nxt_addr;
      active     <= nxt_active;
      loop_pulse <= nxt_pulse;
    end
  end

endmodule

// File: rtl/sample_voice_addr_gen.sv
// Multi-voice sample-playback address generator: NUM_VOICES independent
// voice channels sharing one sample-rate tick, outputs packed per voice.
// Build option: SAMPLER_PINGPONG_EN enables ping-pong playback for mode 2.
module sample_voice_addr_gen
  import sampler_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int BRAM_DEPTH = 8192,
  parameter int ADDR_WIDTH = 13
) (
  input logic                    clk_in,
  input logic                    rst_in,
  sample_voice_addr_gen_if.slave bus
);

  if (ADDR_WIDTH != $clog2(BRAM_DEPTH)) begin : g_width_check
    $error("ADDR_WIDTH must equal clog2(BRAM_DEPTH)");
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_addr_channel #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_channel (
      .clk         (clk_in),
      .rst         (rst_in),
      .sample_tick (bus.sample_tick),
      .gate        (bus.gate_in[v]),
      .mode        (bus.mode_in[2*v +: 2]),
      .start_addr  (bus.start_addr_in[v*ADDR_WIDTH +: ADDR_WIDTH]),
      .end_addr    (bus.end_addr_in[v*ADDR_WIDTH +: ADDR_WIDTH]),
      .addr        (bus.sample_addr[v*ADDR_WIDTH +: ADDR_WIDTH]),
      .active      (bus.voice_active[v]),
      .loop_pulse  (bus.loop_pulse[v])
    );
  end

endmodule

// File: tb/tb_sample_voice_addr_gen.sv
// Directed bench for sample_voice_addr_gen; expectations track SAMPLER_PINGPONG_EN.
module tb_sample_voice_addr_gen;

  localparam int NV = 4;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  sample_voice_addr_gen_if #(.NUM_VOICES(NV), .ADDR_WIDTH(AW)) bus ();

  sample_voice_addr_gen #(
    .NUM_VOICES (NV),
    .BRAM_DEPTH (8192),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int v);
    return 32'(bus.sample_addr[v*AW +: AW]);
  endfunction

  task automatic set_voice(input int v, input logic [1:0] m, input int s, input int e);
    bus.mode_in[2*v +: 2]         = m;
    bus.start_addr_in[v*AW +: AW] = AW'(s);
    bus.end_addr_in[v*AW +: AW]   = AW'(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
  endtask

  int exp_a [7];
  int exp_p [7];

  initial begin
    bus.sample_tick   = 1'b0;
    bus.gate_in       = '0;
    bus.mode_in       = '0;
    bus.start_addr_in = '0;
    bus.end_addr_in   = '0;

    // Reset with voice 0 gate already high
    set_voice(0, 2'd0, 10, 13);
    bus.gate_in[0] = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_addr", 32'(bus.sample_addr), 0);
    chk("rst_active", 32'(bus.voice_active), 0);
    chk("rst_pulse", 32'(bus.loop_pulse), 0);
    #9 rst = 1'b0;
    step();
    chk("os_trig_addr", addr_of(0), 10);
    chk("os_trig_active", 32'(bus.voice_active[0]), 1);

    // One-shot 10..13 with a tick every 4 cycles
    exp_a[0] = 11; exp_a[1] = 12; exp_a[2] = 13; exp_a[3] = 13; exp_a[4] = 13;
    for (int i = 0; i < 5; i++) begin
      repeat (3) step();
      tick();
      chk($sformatf("os_addr_t%0d", i + 1), addr_of(0), 32'(exp_a[i]));
      chk($sformatf("os_active_t%0d", i + 1), 32'(bus.voice_active[0]), (i < 3) ? 1 : 0);
      chk($sformatf("os_pulse_t%0d", i + 1), 32'(bus.loop_pulse[0]), 0);
    end
    repeat (2) step();
    chk("os_hold_addr", addr_of(0), 13);
    bus.gate_in[0] = 1'b0;
    step();
    chk("os_gate_off_addr", addr_of(0), 0);

    // Loop 100..102
    set_voice(1, 2'd1, 100, 102);
    bus.gate_in[1] = 1'b1;
    step();
    chk("lp_trig_addr", addr_of(1), 100);
    exp_a = '{101, 102, 100, 101, 102, 100, 101};
    exp_p = '{0, 0, 1, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("lp_addr_t%0d", i + 1), addr_of(1), 32'(exp_a[i]));
      chk($sformatf("lp_pulse_t%0d", i + 1), 32'(bus.loop_pulse[1]), 32'(exp_p[i]));
      step();
      chk($sformatf("lp_pulse_idle%0d", i + 1), 32'(bus.loop_pulse[1]), 0);
    end
    bus.gate_in[1] = 1'b0;
    step();

    // Mode 2, 5..7: ping-pong when enabled, otherwise identical to loop
    set_voice(2, 2'd2, 5, 7);
    bus.gate_in[2] = 1'b1;
    step();
    chk("pp_trig_addr", addr_of(2), 5);
`ifdef SAMPLER_PINGPONG_EN
    exp_a = '{6, 7, 6, 5, 6, 7, 6};
    exp_p = '{0, 0, 1, 0, 1, 0, 1};
`else
    exp_a = '{6, 7, 5, 6, 7, 5, 6};
    exp_p = '{0, 0, 1, 0, 0, 1, 0};
`endif
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("pp_addr_t%0d", i + 1), addr_of(2), 32'(exp_a[i]));
      chk($sformatf("pp_pulse_t%0d", i + 1), 32'(bus.loop_pulse[2]), 32'(exp_p[i]));
    end
    bus.gate_in[2] = 1'b0;
    step();

    // end < start clamps to a single-sample loop
    set_voice(3, 2'd1, 8, 3);
    bus.gate_in[3] = 1'b1;
    step();
    chk("clamp_trig_addr", addr_of(3), 8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("clamp_addr_t%0d", i + 1), addr_of(3), 8);
      chk($sformatf("clamp_pulse_t%0d", i + 1), 32'(bus.loop_pulse[3]), 1);
    end
    step();
    chk("clamp_pulse_idle", 32'(bus.loop_pulse[3]), 0);

    // Gate rise coincident with tick: start loads, no advance
    bus.gate_in[3] = 1'b0;
    step();
    set_voice(3, 2'd1, 20, 30);
    bus.gate_in[3] = 1'b1;
    tick();
    chk("coinc_addr", addr_of(3), 20);
    chk("coinc_pulse", 32'(bus.loop_pulse[3]), 0);
    set_voice(3, 2'd1, 500, 600);
    tick();
    chk("coinc_next_addr", addr_of(3), 21);
    bus.gate_in[3] = 1'b0;
    step();

    // Voice 0 loop and voice 2 one-shot; voice 0 released mid-play
    set_voice(0, 2'd1, 40, 42);
    set_voice(2, 2'd0, 200, 210);
    bus.gate_in[0] = 1'b1;
    bus.gate_in[2] = 1'b1;
    step();
    tick();
    tick();
    chk("ind_v0_addr", addr_of(0), 42);
    chk("ind_v2_addr", addr_of(2), 202);
    bus.gate_in[0] = 1'b0;
    step();
    chk("ind_v0_off_addr", addr_of(0), 0);
    chk("ind_active", 32'(bus.voice_active), 32'h4);
    chk("ind_v2_hold_addr", addr_of(2), 202);
    tick();
    chk("ind_v2_tick_addr", addr_of(2), 203);
    chk("ind_v0_tick_addr", addr_of(0), 0);

    // Asynchronous reset between edges while voice 2 plays
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", 32'(bus.sample_addr), 0);
    chk("arst_active", 32'(bus.voice_active), 0);
    chk("arst_pulse", 32'(bus.loop_pulse), 0);
    #2 rst = 1'b0;
    step();
    chk("arst_retrig_addr", addr_of(2), 200);
    chk("arst_retrig_active", 32'(bus.voice_active), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
